// File: rtl/ps2_key_tracker_pkg.sv
// Shared scan-code constants, event record, fetch-state encoding and the
// hex-to-segment lookup for the PS/2 key tracker.
package ps2_key_tracker_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } kb_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACK,
        ST_GAP
    } fetch_state_t;

    // Active-high pattern, bit order {a,b,c,d,e,f,g,dp}; dp is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0: seg = 8'hFC;
            4'h1: seg = 8'h60;
            4'h2: seg = 8'hDA;
            4'h3: seg = 8'hF2;
            4'h4: seg = 8'h66;
            4'h5: seg = 8'hB6;
            4'h6: seg = 8'hBE;
            4'h7: seg = 8'hE0;
            4'h8: seg = 8'hFE;
            4'h9: seg = 8'hF6;
            4'hA: seg = 8'hEE;
            4'hB: seg = 8'h3E;
            4'hC: seg = 8'h9C;
            4'hD: seg = 8'h7A;
            4'hE: seg = 8'h9E;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ps2_key_tracker_seg7_hex.sv
// One hex digit to a 7-segment pattern, with optional blanking and output
// polarity selected by SEG_ACTIVE_LOW.
module seg7_hex
    import ps2_key_tracker_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    logic [7:0] w_seg_pos;

    assign w_seg_pos = i_blank ? SEG_BLANK : hex_to_seg(i_nibble);
    assign o_seg     = (SEG_ACTIVE_LOW != 0) ? ~w_seg_pos : w_seg_pos;

endmodule

// File: rtl/ps2_key_tracker.sv
// Pulls scan-code bytes from a PS/2 receiver FIFO, decodes E0/F0 prefixes
// into make/break events, queues them, and tracks the held key and press count.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int EVT_DEPTH      = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           kb_data,
    input  logic                 kb_ready,
    output logic                 kb_nextdata_n,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [7:0]           evt_code,
    output logic                 evt_ext,
    output logic                 evt_brk,
    output logic                 evt_overflow,
    output logic                 key_held,
    output logic [7:0]           last_code,
    output logic [CNT_W-1:0]     press_cnt,
    output logic [15:0]          seg_code,
    output logic [2*CNT_W-1:0]   seg_cnt
);

    localparam int PTR_W = $clog2(EVT_DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_nextdata_n;
    logic [7:0]   r_byte;
    logic         r_ext_pend;
    logic         r_brk_pend;

    logic             r_key_held;
    logic [7:0]       r_held_code;
    logic             r_held_ext;
    logic [7:0]       r_last_code;
    logic             r_code_vld;
    logic [CNT_W-1:0] r_press_cnt;

    kb_evt_t        r_mem [EVT_DEPTH];
    logic [PTR_W:0] r_wr_ptr;
    logic [PTR_W:0] r_rd_ptr;
    logic           r_overflow;

    // ---------------- fetch FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_nextdata_n <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_nextdata_n <= (w_state_nxt != ST_ACK);
        end
    end

    // NOTE: combinational blocks assign every output a default first so no path leaves a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (kb_ready) w_state_nxt = ST_ACK;
            ST_ACK:  w_state_nxt = ST_GAP;
            ST_GAP:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte <= 8'h00;
        end else if (r_state == ST_IDLE && kb_ready) begin
            r_byte <= kb_data;
        end
    end

    // ---------------- decoder ----------------
    logic    w_decode;
    logic    w_evt_fire;
    logic    w_match;
    logic    w_make;
    logic    w_break;
    logic    w_push;
    kb_evt_t w_evt;

    // The captured byte is decoded while the FSM sits in ACK.
    assign w_decode   = (r_state == ST_ACK);
    assign w_evt_fire = w_decode && (r_byte != SC_EXT) && (r_byte != SC_BRK);
    assign w_match    = r_key_held && (r_held_code == r_byte) && (r_held_ext == r_ext_pend);
    assign w_make     = w_evt_fire && !r_brk_pend && !w_match;
    assign w_break    = w_evt_fire && r_brk_pend;
    assign w_push     = w_make || w_break;
    assign w_evt      = '{code: r_byte, ext: r_ext_pend, brk: r_brk_pend};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
        end else if (w_decode) begin
            if (r_byte == SC_EXT) begin
                r_ext_pend <= 1'b1;
            end else if (r_byte == SC_BRK) begin
                r_brk_pend <= 1'b1;
            end else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_held  <= 1'b0;
            r_held_code <= 8'h00;
            r_held_ext  <= 1'b0;
            r_last_code <= 8'h00;
            r_code_vld  <= 1'b0;
            r_press_cnt <= '0;
        end else if (w_make) begin
            r_key_held  <= 1'b1;
            r_held_code <= r_byte;
            r_held_ext  <= r_ext_pend;
            r_last_code <= r_byte;
            r_code_vld  <= 1'b1;
            r_press_cnt <= r_press_cnt + CNT_W'(1);
        end else if (w_break && w_match) begin
            r_key_held  <= 1'b0;
        end
    end

    // ---------------- event FIFO ----------------
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_pop   = !w_empty && evt_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    // NOTE: storage carries no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    kb_evt_t w_head;
    assign w_head = r_mem[r_rd_ptr[PTR_W-1:0]];

    assign kb_nextdata_n = r_nextdata_n;
    assign evt_valid     = !w_empty;
    assign evt_code      = w_head.code;
    assign evt_ext       = w_head.ext;
    assign evt_brk       = w_head.brk;
    assign evt_overflow  = r_overflow;
    assign key_held      = r_key_held;
    assign last_code     = r_last_code;
    assign press_cnt     = r_press_cnt;

    // ---------------- displays ----------------
    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_code_hi (
        .i_nibble (r_last_code[7:4]),
        .i_blank  (!r_code_vld),
        .o_seg    (seg_code[15:8])
    );

    seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_code_lo (
        .i_nibble (r_last_code[3:0]),
        .i_blank  (!r_code_vld),
        .o_seg    (seg_code[7:0])
    );

    for (genvar g = 0; g < CNT_W/4; g++) begin : g_seg_cnt
        seg7_hex #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_cnt (
            .i_nibble (r_press_cnt[4*g +: 4]),
            .i_blank  (1'b0),
            .o_seg    (seg_cnt[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a default instance plus a CNT_W=4,
// active-high-segment instance sharing the same keyboard and consumer inputs.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       evt_ready = 1'b0;

    logic        kb_nextdata_n, evt_valid, evt_ext, evt_brk, evt_overflow, key_held;
    logic [7:0]  evt_code, last_code, press_cnt;
    logic [15:0] seg_code, seg_cnt;

    logic        kb_nextdata_n2, evt_valid2, evt_ext2, evt_brk2, evt_overflow2, key_held2;
    logic [7:0]  evt_code2, last_code2;
    logic [3:0]  press_cnt2;
    logic [15:0] seg_code2;
    logic [7:0]  seg_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] g_bytes [$];
    logic [9:0] g_evts  [$];

    ps2_key_tracker dut (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(kb_nextdata_n), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk),
        .evt_overflow(evt_overflow), .key_held(key_held), .last_code(last_code),
        .press_cnt(press_cnt), .seg_code(seg_code), .seg_cnt(seg_cnt)
    );

    ps2_key_tracker #(.CNT_W(4), .EVT_DEPTH(4), .SEG_ACTIVE_LOW(0)) dut2 (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(kb_nextdata_n2), .evt_valid(evt_valid2), .evt_ready(evt_ready),
        .evt_code(evt_code2), .evt_ext(evt_ext2), .evt_brk(evt_brk2),
        .evt_overflow(evt_overflow2), .key_held(key_held2), .last_code(last_code2),
        .press_cnt(press_cnt2), .seg_code(seg_code2), .seg_cnt(seg_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; kb_ready = 1'b0; evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Receiver model: presents g_bytes in order, advancing on each pop strobe.
    task automatic feed(input bit pop_in_ack, output int pulses);
        int waited;
        pulses = 0;
        if (g_bytes.size() == 0) return;
        @(negedge clk);
        kb_data = g_bytes[0]; kb_ready = 1'b1;
        for (int i = 0; i < g_bytes.size(); i++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (kb_nextdata_n !== 1'b0 && waited < 20);
            if (kb_nextdata_n !== 1'b0) begin
                n_checks++; n_fail++;
                $display("FAIL feed_timeout byte %0d: no pop strobe within 20 cycles", i);
                kb_ready = 1'b0;
                g_bytes.delete();
                return;
            end
            pulses++;
            if (i + 1 < g_bytes.size()) kb_data = g_bytes[i+1];
            else kb_ready = 1'b0;
            if (pop_in_ack) evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
            n_checks++;
            if (kb_nextdata_n !== 1'b1) begin
                n_fail++;
                $display("FAIL pulse_width byte %0d: kb_nextdata_n=%b want 1", i, kb_nextdata_n);
            end
        end
        g_bytes.delete();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < g_evts.size(); i++) begin
            n_checks++;
            if (evt_valid !== 1'b1 || {evt_code, evt_ext, evt_brk} !== g_evts[i]) begin
                n_fail++;
                $display("FAIL %s evt%0d: got valid=%b code=%h ext=%b brk=%b want code=%h ext=%b brk=%b",
                         name, i, evt_valid, evt_code, evt_ext, evt_brk,
                         g_evts[i][9:2], g_evts[i][1], g_evts[i][0]);
            end
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s empty_after_drain: evt_valid=%b want 0", name, evt_valid);
        end
        g_evts.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (kb_nextdata_n !== 1'b1 || evt_valid !== 1'b0 || evt_overflow !== 1'b0 || key_held !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: nextdata_n=%b valid=%b ovf=%b held=%b want 1 0 0 0",
                     kb_nextdata_n, evt_valid, evt_overflow, key_held);
        end
        n_checks++;
        if (last_code !== 8'h00 || press_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_regs: last_code=%h press_cnt=%h want 00 00", last_code, press_cnt);
        end
        n_checks++;
        if (seg_code !== 16'hFFFF || seg_cnt !== 16'h0303) begin
            n_fail++;
            $display("FAIL reset_seg: seg_code=%h seg_cnt=%h want ffff 0303", seg_code, seg_cnt);
        end
        n_checks++;
        if (seg_code2 !== 16'h0000 || seg_cnt2 !== 8'hFC) begin
            n_fail++;
            $display("FAIL reset_seg_ah: seg_code=%h seg_cnt=%h want 0000 fc", seg_code2, seg_cnt2);
        end
    endtask

    task automatic test_single();
        do_reset();
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_empty_pop: evt_valid=%b want 0", evt_valid);
        end
        kb_data = 8'h15; kb_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (kb_nextdata_n !== 1'b0 || evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: nextdata_n=%b valid=%b want 0 0", kb_nextdata_n, evt_valid);
        end
        kb_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (kb_nextdata_n !== 1'b1 || evt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_latency: nextdata_n=%b valid=%b want 1 1", kb_nextdata_n, evt_valid);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (kb_nextdata_n !== 1'b1 || press_cnt !== 8'h01 || last_code !== 8'h15 || key_held !== 1'b1) begin
            n_fail++;
            $display("FAIL single_state: nextdata_n=%b cnt=%h last=%h held=%b want 1 01 15 1",
                     kb_nextdata_n, press_cnt, last_code, key_held);
        end
        n_checks++;
        if (seg_code !== 16'h9F49 || seg_cnt !== 16'h039F) begin
            n_fail++;
            $display("FAIL single_seg: seg_code=%h seg_cnt=%h want 9f49 039f", seg_code, seg_cnt);
        end
        g_evts.push_back({8'h15, 1'b0, 1'b0});
        drain("single");
    endtask

    task automatic test_make_break();
        int p;
        do_reset();
        g_bytes.push_back(8'h15); g_bytes.push_back(8'hF0); g_bytes.push_back(8'h15);
        feed(1'b0, p);
        n_checks++;
        if (p != 3 || key_held !== 1'b0 || press_cnt !== 8'h01) begin
            n_fail++;
            $display("FAIL make_break: pulses=%0d held=%b cnt=%h want 3 0 01", p, key_held, press_cnt);
        end
        g_evts.push_back({8'h15, 1'b0, 1'b0});
        g_evts.push_back({8'h15, 1'b0, 1'b1});
        drain("make_break");
    endtask

    task automatic test_typematic();
        int p;
        do_reset();
        repeat (3) g_bytes.push_back(8'h1C);
        feed(1'b0, p);
        n_checks++;
        if (p != 3 || key_held !== 1'b1 || press_cnt !== 8'h01 || last_code !== 8'h1C) begin
            n_fail++;
            $display("FAIL typematic: pulses=%0d held=%b cnt=%h last=%h want 3 1 01 1c",
                     p, key_held, press_cnt, last_code);
        end
        g_evts.push_back({8'h1C, 1'b0, 1'b0});
        drain("typematic");
    endtask

    task automatic test_extended();
        int p;
        do_reset();
        g_bytes.push_back(8'hE0); g_bytes.push_back(8'h75);
        g_bytes.push_back(8'hE0); g_bytes.push_back(8'hF0); g_bytes.push_back(8'h75);
        feed(1'b0, p);
        n_checks++;
        if (p != 5 || key_held !== 1'b0 || press_cnt !== 8'h01) begin
            n_fail++;
            $display("FAIL extended: pulses=%0d held=%b cnt=%h want 5 0 01", p, key_held, press_cnt);
        end
        g_evts.push_back({8'h75, 1'b1, 1'b0});
        g_evts.push_back({8'h75, 1'b1, 1'b1});
        drain("extended");
    endtask

    task automatic test_overflow();
        int p;
        do_reset();
        g_bytes.push_back(8'h15); g_bytes.push_back(8'h1C); g_bytes.push_back(8'h23);
        g_bytes.push_back(8'h24); g_bytes.push_back(8'h2B);
        feed(1'b0, p);
        n_checks++;
        if (evt_overflow !== 1'b1 || press_cnt !== 8'h05 || last_code !== 8'h2B) begin
            n_fail++;
            $display("FAIL overflow: ovf=%b cnt=%h last=%h want 1 05 2b", evt_overflow, press_cnt, last_code);
        end
        g_evts.push_back({8'h15, 1'b0, 1'b0}); g_evts.push_back({8'h1C, 1'b0, 1'b0});
        g_evts.push_back({8'h23, 1'b0, 1'b0}); g_evts.push_back({8'h24, 1'b0, 1'b0});
        drain("overflow");
        n_checks++;
        if (evt_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: ovf=%b want 1", evt_overflow);
        end
    endtask

    task automatic test_full_pop();
        int p;
        do_reset();
        g_bytes.push_back(8'h15); g_bytes.push_back(8'h1C);
        g_bytes.push_back(8'h23); g_bytes.push_back(8'h24);
        feed(1'b0, p);
        g_bytes.push_back(8'h2B);
        feed(1'b1, p);
        n_checks++;
        if (evt_overflow !== 1'b0 || press_cnt !== 8'h05) begin
            n_fail++;
            $display("FAIL full_pop: ovf=%b cnt=%h want 0 05", evt_overflow, press_cnt);
        end
        g_evts.push_back({8'h1C, 1'b0, 1'b0}); g_evts.push_back({8'h23, 1'b0, 1'b0});
        g_evts.push_back({8'h24, 1'b0, 1'b0}); g_evts.push_back({8'h2B, 1'b0, 1'b0});
        drain("full_pop");
    endtask

    task automatic test_wrap();
        int p;
        do_reset();
        for (int c = 8'h10; c <= 8'h1F; c++) begin
            g_bytes.push_back(8'(c)); g_bytes.push_back(8'hF0); g_bytes.push_back(8'(c));
        end
        feed(1'b0, p);
        n_checks++;
        if (p != 48 || press_cnt2 !== 4'h0 || press_cnt !== 8'h10 || key_held2 !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_cnt: pulses=%0d cnt4=%h cnt8=%h held=%b want 48 0 10 0",
                     p, press_cnt2, press_cnt, key_held2);
        end
        n_checks++;
        if (seg_cnt !== 16'h9F03 || seg_cnt2 !== 8'hFC || seg_code2 !== 16'h608E) begin
            n_fail++;
            $display("FAIL wrap_seg: seg_cnt=%h seg_cnt4=%h seg_code_ah=%h want 9f03 fc 608e",
                     seg_cnt, seg_cnt2, seg_code2);
        end
    endtask

    task automatic test_reset_mid();
        int p;
        int waited;
        do_reset();
        g_bytes.push_back(8'hE0);
        feed(1'b0, p);
        do_reset();
        g_bytes.push_back(8'h15);
        feed(1'b0, p);
        g_evts.push_back({8'h15, 1'b0, 1'b0});
        drain("reset_after_e0");

        do_reset();
        kb_data = 8'hE0; kb_ready = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (kb_nextdata_n !== 1'b0 && waited < 20);
        rst = 1'b1; kb_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (waited >= 20 || kb_nextdata_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ack: waited=%0d nextdata_n=%b want <20 1", waited, kb_nextdata_n);
        end
        g_bytes.push_back(8'h15);
        feed(1'b0, p);
        n_checks++;
        if (press_cnt !== 8'h01) begin
            n_fail++;
            $display("FAIL reset_in_ack_cnt: cnt=%h want 01", press_cnt);
        end
        g_evts.push_back({8'h15, 1'b0, 1'b0});
        drain("reset_in_ack");
    endtask

    initial begin
        test_reset();
        test_single();
        test_make_break();
        test_typematic();
        test_extended();
        test_overflow();
        test_full_pop();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
